// File: rtl/dcache_refill_unit.sv
// dcache_refill_unit: L1 D-cache miss-service engine.
// Accepts a read/write miss and fetches the 1024-bit block from the next level
// as eight 128-bit beats. It assembles the block and returns it on the fill
// port with a one-cycle repair_resolved pulse. The missed 32-bit word is
// forwarded early on crit_word/crit_word_valid.
//
// Optional feature: define DCACHE_REFILL_CWF_EN for critical-word-first beat
// ordering. When it is undefined, beats are requested in order 0..7.
//
// Ports:
//   clk, rst                       clock, async active-low reset
//   read_repair_request            read miss from cache controller
//   write_miss_repair              write miss from cache controller
//   missed_addr                    byte address of the missing access
//   repair_resolved, fill_valid    one-cycle pulse, block on fill port
//   fill_addr, fill_data, fill_mask  block-aligned fill write
//   mem_req_valid/ready            memory request handshake
//   mem_req_addr                   block-aligned request address
//   mem_req_first_beat             first beat index requested
//   mem_rsp_valid/ready, mem_rsp_data  response beats
//   crit_word_valid, crit_word     early forward of the missed word
//   busy                           engine not idle
module dcache_refill_unit #(
  parameter int unsigned BLOCK_BITS = 1024,
  parameter int unsigned BEAT_BITS  = 128,
  parameter int unsigned ADDR_BITS  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    read_repair_request,
  input  logic                    write_miss_repair,
  input  logic [ADDR_BITS-1:0]    missed_addr,
  output logic                    repair_resolved,
  output logic                    fill_valid,
  output logic [ADDR_BITS-1:0]    fill_addr,
  output logic [BLOCK_BITS-1:0]   fill_data,
  output logic [BLOCK_BITS/8-1:0] fill_mask,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [ADDR_BITS-1:0]    mem_req_addr,
  output logic [2:0]              mem_req_first_beat,
  input  logic                    mem_rsp_valid,
  output logic                    mem_rsp_ready,
  input  logic [BEAT_BITS-1:0]    mem_rsp_data,
  output logic                    crit_word_valid,
  output logic [31:0]             crit_word,
  output logic                    busy
);

  localparam int unsigned NUM_BEATS     = BLOCK_BITS / BEAT_BITS;
  localparam int unsigned BEAT_IDX_BITS = 3;
  localparam int unsigned OFFSET_BITS   = $clog2(BLOCK_BITS / 8);
  localparam int unsigned WORD_BITS     = 32;
  localparam int unsigned WORD_SEL_BITS = $clog2(BEAT_BITS / WORD_BITS);
  localparam int unsigned WORD_LSB      = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RECV = 2'd2,
    FILL = 2'd3
  } state_t;

  state_t                     state_q;
  state_t                     state_d;
  logic [BEAT_IDX_BITS-1:0]   cnt_q;
  logic [BEAT_IDX_BITS-1:0]   crit_beat_q;
  logic [WORD_SEL_BITS-1:0]   crit_word_sel_q;
  logic                       miss_accept_c;
  logic                       rsp_accept_c;
  logic                       last_beat_c;
  logic [BEAT_IDX_BITS-1:0]   beat_idx_c;
  logic [ADDR_BITS-1:0]       block_addr_c;
  logic                       unused_addr_bits_c;

  // Byte-within-word bits never matter for a block fetch.
  assign unused_addr_bits_c = ^missed_addr[WORD_LSB-1:0];

  assign block_addr_c = {missed_addr[ADDR_BITS-1:OFFSET_BITS], OFFSET_BITS'(0)};

  // Handshake qualifiers and beat placement (wraps modulo 8).
  always_comb begin
    miss_accept_c = 1'b0;
    rsp_accept_c  = 1'b0;
    last_beat_c   = 1'b0;
    beat_idx_c    = mem_req_first_beat + cnt_q;
    if (state_q == IDLE) begin
      miss_accept_c = read_repair_request | write_miss_repair;
    end
    if (state_q == RECV) begin
      rsp_accept_c = mem_rsp_valid;
      last_beat_c  = mem_rsp_valid && (cnt_q == BEAT_IDX_BITS'(NUM_BEATS - 1));
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (miss_accept_c) state_d = REQ;
      REQ:  if (mem_req_ready) state_d = RECV;
      RECV: if (last_beat_c)   state_d = FILL;
      FILL: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Registered outputs track the state being entered, so they line up with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req_valid   <= 1'b0;
      mem_rsp_ready   <= 1'b0;
      fill_valid      <= 1'b0;
      repair_resolved <= 1'b0;
      fill_mask       <= '0;
      busy            <= 1'b0;
    end else begin
      mem_req_valid   <= (state_d == REQ);
      mem_rsp_ready   <= (state_d == RECV);
      fill_valid      <= (state_d == FILL);
      repair_resolved <= (state_d == FILL);
      fill_mask       <= (state_d == FILL) ? '1 : '0;
      busy            <= (state_d != IDLE);
    end
  end

  // Miss capture: the address is held here so the controller may change it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req_addr       <= '0;
      fill_addr          <= '0;
      mem_req_first_beat <= '0;
      crit_beat_q        <= '0;
      crit_word_sel_q    <= '0;
    end else if (miss_accept_c) begin
      mem_req_addr    <= block_addr_c;
      fill_addr       <= block_addr_c;
      crit_beat_q     <= missed_addr[OFFSET_BITS-1 -: BEAT_IDX_BITS];
      crit_word_sel_q <= missed_addr[WORD_LSB +: WORD_SEL_BITS];
`ifdef DCACHE_REFILL_CWF_EN
      mem_req_first_beat <= missed_addr[OFFSET_BITS-1 -: BEAT_IDX_BITS];
`else
      mem_req_first_beat <= '0;
`endif
    end
  end

  // Beat assembly and critical-word forward.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q           <= '0;
      fill_data       <= '0;
      crit_word       <= '0;
      crit_word_valid <= 1'b0;
    end else begin
      crit_word_valid <= rsp_accept_c && (beat_idx_c == crit_beat_q);
      if (miss_accept_c) begin
        cnt_q <= '0;
      end else if (rsp_accept_c) begin
        cnt_q <= cnt_q + BEAT_IDX_BITS'(1);
      end
      if (rsp_accept_c) begin
        fill_data[int'(beat_idx_c)*BEAT_BITS +: BEAT_BITS] <= mem_rsp_data;
        if (beat_idx_c == crit_beat_q) begin
          crit_word <= mem_rsp_data[int'(crit_word_sel_q)*WORD_BITS +: WORD_BITS];
        end
      end
    end
  end

endmodule

// File: doc/dcache_refill_unit.md
# dcache_refill_unit

Miss-service engine on the arbiter side of the L1 data cache's repair interface. Accepts a read or write miss from the cache controller, fetches the 1024-bit block from the next memory level as eight 128-bit beats, assembles it, and writes it back into the cache through the fill path with a one-cycle `repair_resolved` pulse. It also forwards the missed 32-bit word early for the load pipeline.

## Interface
Parameters:
- `BLOCK_BITS`, 1024: cache block width; fixed at 1024.
- `BEAT_BITS`, 128: memory response beat width; `BLOCK_BITS/BEAT_BITS` = 8 beats.
- `ADDR_BITS`, 32: address width.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `read_repair_request` in 1: read miss from cache controller.
- `write_miss_repair` in 1: write miss from cache controller.
- `missed_addr` in 32: byte address of the missing access.
- `repair_resolved` out 1: one-cycle pulse; the block is on the fill port this cycle.
- `fill_valid` out 1: fill write strobe; coincident with `repair_resolved`.
- `fill_addr` out 32: block-aligned address (`[6:0]`=0).
- `fill_data` out 1024: assembled block.
- `fill_mask` out 128: all ones when `fill_valid`, else 0.
- `mem_req_valid` out 1, `mem_req_ready` in 1: memory request handshake.
- `mem_req_addr` out 32: block-aligned address.
- `mem_req_first_beat` out 3: index of the first beat requested.
- `mem_rsp_valid` in 1, `mem_rsp_ready` out 1, `mem_rsp_data` in 128: response beats.
- `crit_word_valid` out 1, `crit_word` out 32: early forward of the missed word.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, REQ, RECV, FILL.
- IDLE: when `read_repair_request | write_miss_repair` is high, latch `missed_addr` and go to REQ. A simultaneous read and write miss is treated as a single miss.
- REQ: `mem_req_valid`=1 until `mem_req_ready`, then go to RECV.
- RECV: `mem_rsp_ready`=1. Each accepted beat is written to `fill_data[beat_idx*128 +: 128]`.
  - `beat_idx = (first_beat + cnt) mod 8`, where `cnt` is a 3-bit counter.
  - After 8 accepted beats, go to FILL.
- FILL: `fill_valid`=`repair_resolved`=1 for exactly one cycle, then go to IDLE.
- Critical word: beat `missed_addr[6:4]`, word `missed_addr[3:2]` within that beat. `crit_word_valid` pulses for one cycle on the cycle after that beat is accepted.
- Miss inputs outside IDLE are ignored; the controller holds its stall until `repair_resolved`.
- `mem_rsp_valid` outside RECV is ignored; `mem_rsp_ready`=0.
- `fill_data` holds its value after FILL until the next miss's first beat overwrites it.

## Timing
- Reset values: all 1-bit outputs 0, `fill_data`/`fill_addr`/`mem_req_addr`/`crit_word`/`fill_mask` 0, `mem_req_first_beat` 0, state IDLE.
- Miss sampled at edge t gives `mem_req_valid` at t+1.
- With `mem_req_ready` and `mem_rsp_valid` always high: request handshake at t+1, beats at t+2..t+9, `repair_resolved` at t+10, IDLE at t+11. A new miss is accepted at t+11.
- Response gaps (`mem_rsp_valid`=0) stall the counter and do not change the beat order.
- Reset mid-operation aborts immediately: state goes to IDLE and all outputs clear. The memory side must discard any outstanding beats after reset.

## Configuration
- `DCACHE_REFILL_CWF_EN` defined: critical-word-first ordering.
  - `mem_req_first_beat = missed_addr[6:4]`; beats wrap modulo 8.
  - `crit_word_valid` is always on the cycle after the first beat.
- Undefined:
  - `mem_req_first_beat` = 0; beats arrive in order 0..7.
  - `crit_word_valid` fires after beat `missed_addr[6:4]`.

## Test plan
- Read miss, `missed_addr`=0x0000_1234, memory always ready, beat k data = {4{k,k,k,k in bytes}} -> `mem_req_addr`=0x0000_1200; `repair_resolved` 10 cycles after the request edge; `fill_data` slice k matches beat k; `fill_mask`=all ones for one cycle.
- CWF on, `missed_addr`=0x0000_0078 -> `mem_req_first_beat`=7; beats placed at indices 7,0,1..6; `crit_word` = beat-7 data word 2, valid the cycle after the first beat.
- CWF off, same address -> first beat 0; `crit_word_valid` after the 8th beat; final `fill_data` identical to the CWF-on case.
- `mem_req_ready` low for 3 cycles and `mem_rsp_valid` dropped between beats 3 and 4 for 2 cycles -> completion delayed exactly 5 cycles; data is correct.
- Read and write miss asserted together, then a second miss during RECV -> exactly one memory request; the second miss is ignored; `busy` stays high until FILL.
- `rst` pulled low after beat 4 -> all outputs 0 asynchronously; a new miss after release starts a fresh 8-beat fetch.
